// File: rtl/jt_sfg_bus.sv
// MSX cartridge bus front-end for the SFG sound unit. It synchronises the bus strobes,
// stretches accesses with WAIT, sequences the device strobes and answers interrupt acknowledge.
module jt_sfg_bus #(
  parameter logic [15:0] BASE     = 16'h3FF0,
  parameter int unsigned AW       = 3,
  parameter int unsigned WAIT_MIN = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   addr,
  input  logic [7:0]    din,
  input  logic          wr_n,
  input  logic          rd_n,
  input  logic          slt_n,
  input  logic          iorq_n,
  input  logic          m1_n,
  output logic [7:0]    dout,
  output logic          dout_en,
  output logic          wait_n,
  output logic          int_n,
  output logic [AW-1:0] dev_addr,
  output logic [7:0]    dev_wdata,
  output logic          dev_wr,
  output logic          dev_rd,
  input  logic [7:0]    dev_rdata,
  input  logic          dev_busy,
  input  logic          opm_irq_n,
  input  logic          midi_irq,
  input  logic          ext_irq
);

  localparam int unsigned CW = 4;
  localparam logic [AW-1:0] OFF_MIDI = AW'(3);
  localparam logic [AW-1:0] OFF_EXT  = AW'(4);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_XFER, ST_HOLD} state_e;

  // Read post-processing phase in HOLD: none, latch data, release wait
  localparam logic [1:0] PH_NONE  = 2'd0;
  localparam logic [1:0] PH_LATCH = 2'd1;
  localparam logic [1:0] PH_REL   = 2'd2;

  state_e        state_q, state_d;
  logic [4:0]    s1_q, s2_q;
  logic [1:0]    strb_p_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          is_rd_q, is_rd_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          dev_wr_q, dev_wr_d;
  logic          dev_rd_q, dev_rd_d;
  logic          wait_n_q, wait_n_d;
  logic [7:0]    dout_q, dout_d;
  logic          dout_en_q, dout_en_d;
  logic [1:0]    ph_q, ph_d;
  logic [7:0]    vec_midi_q, vec_midi_d;
  logic [7:0]    vec_ext_q, vec_ext_d;
  logic          ack_q, ack_d;
  logic          int_n_q;

  logic wr_s, rd_s, slt_s, iorq_s, m1_s;
  logic wr_fall, rd_fall, hit, start_wr, start_rd, int_reg;
  logic [7:0] vec_sel;

  assign wr_s   = s2_q[0];
  assign rd_s   = s2_q[1];
  assign slt_s  = s2_q[2];
  assign iorq_s = s2_q[3];
  assign m1_s   = s2_q[4];

  assign wr_fall  = strb_p_q[0] & ~wr_s;
  assign rd_fall  = strb_p_q[1] & ~rd_s;
  assign hit      = ~slt_s & iorq_s & (addr[15:AW] == BASE[15:AW]);
  assign start_wr = hit & wr_fall;
  assign start_rd = hit & rd_fall & ~wr_fall;
  assign int_reg  = (addr_q == OFF_MIDI) || (addr_q == OFF_EXT);
  assign vec_sel  = midi_irq ? vec_midi_q : (ext_irq ? vec_ext_q : 8'hFF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      s1_q       <= '1;
      s2_q       <= '1;
      strb_p_q   <= '1;
      cnt_q      <= '0;
      is_rd_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      dev_wr_q   <= 1'b0;
      dev_rd_q   <= 1'b0;
      wait_n_q   <= 1'b1;
      dout_q     <= 8'h00;
      dout_en_q  <= 1'b0;
      ph_q       <= PH_NONE;
      vec_midi_q <= 8'hFF;
      vec_ext_q  <= 8'hFF;
      ack_q      <= 1'b0;
      int_n_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      s1_q       <= {m1_n, iorq_n, slt_n, rd_n, wr_n};
      s2_q       <= s1_q;
      strb_p_q   <= s2_q[1:0];
      cnt_q      <= cnt_d;
      is_rd_q    <= is_rd_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      dev_wr_q   <= dev_wr_d;
      dev_rd_q   <= dev_rd_d;
      wait_n_q   <= wait_n_d;
      dout_q     <= dout_d;
      dout_en_q  <= dout_en_d;
      ph_q       <= ph_d;
      vec_midi_q <= vec_midi_d;
      vec_ext_q  <= vec_ext_d;
      ack_q      <= ack_d;
      int_n_q    <= ~(midi_irq | ext_irq | ~opm_irq_n);
    end
  end

  // Access sequencer plus interrupt-acknowledge responder
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_rd_d    = is_rd_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    dev_wr_d   = 1'b0;
    dev_rd_d   = 1'b0;
    wait_n_d   = wait_n_q;
    dout_d     = dout_q;
    dout_en_d  = dout_en_q;
    ph_d       = ph_q;
    vec_midi_d = vec_midi_q;
    vec_ext_d  = vec_ext_q;
    ack_d      = ack_q;

    case (state_q)
      ST_IDLE: begin
        if (ack_q) begin
          if (m1_s) begin
            ack_d     = 1'b0;
            dout_en_d = 1'b0;
          end else begin
            dout_d = vec_sel;
          end
        end else if (~m1_s & ~iorq_s & ~int_n_q) begin
          ack_d     = 1'b1;
          dout_en_d = 1'b1;
          dout_d    = vec_sel;
        end else if (start_wr | start_rd) begin
          state_d  = ST_WAIT;
          cnt_d    = CW'(WAIT_MIN);
          is_rd_d  = start_rd;
          addr_d   = addr[AW-1:0];
          wdata_d  = din;
          wait_n_d = 1'b0;
        end
      end
      ST_WAIT: begin
        if (slt_s) begin
          state_d  = ST_HOLD;
          wait_n_d = 1'b1;
          ph_d     = PH_NONE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (!dev_busy) begin
          state_d = ST_XFER;
          if (is_rd_q) begin
            dev_rd_d = ~int_reg;
          end else begin
            dev_wr_d = ~int_reg;
            wait_n_d = 1'b1;
          end
        end
      end
      ST_XFER: begin
        state_d = ST_HOLD;
        if (is_rd_q) begin
          ph_d = PH_LATCH;
        end else begin
          ph_d = PH_NONE;
          if (addr_q == OFF_MIDI) vec_midi_d = wdata_q;
          if (addr_q == OFF_EXT)  vec_ext_d  = wdata_q;
        end
      end
      ST_HOLD: begin
        // dev_rdata is valid the cycle after dev_rd, then wait is released one cycle later
        case (ph_q)
          PH_LATCH: begin
            dout_d    = int_reg ? 8'hFF : dev_rdata;
            dout_en_d = 1'b1;
            ph_d      = PH_REL;
          end
          PH_REL: begin
            wait_n_d = 1'b1;
            ph_d     = PH_NONE;
          end
          default: begin
            if (rd_s) dout_en_d = 1'b0;
            if (rd_s & wr_s) state_d = ST_IDLE;
          end
        endcase
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign dout      = dout_q;
  assign dout_en   = dout_en_q;
  assign wait_n    = wait_n_q;
  assign int_n     = int_n_q;
  assign dev_addr  = addr_q;
  assign dev_wdata = wdata_q;
  assign dev_wr    = dev_wr_q;
  assign dev_rd    = dev_rd_q;

endmodule

// File: tb/tb_jt_sfg_bus.sv
// Directed bench for jt_sfg_bus: writes, busy stretch, reads, internal vectors,
// interrupt acknowledge, misses, abort and reset mid-access.
module tb_jt_sfg_bus;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic [7:0]  din;
  logic        wr_n, rd_n, slt_n, iorq_n, m1_n;
  logic [7:0]  dout;
  logic        dout_en, wait_n, int_n;
  logic [2:0]  dev_addr;
  logic [7:0]  dev_wdata;
  logic        dev_wr, dev_rd;
  logic [7:0]  dev_rdata;
  logic        dev_busy;
  logic        opm_irq_n, midi_irq, ext_irq;

  int n_chk = 0;
  int n_pass = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int wlow = 0;
  logic [2:0] wr_a = '0;
  logic [7:0] wr_d = '0;

  always #5 clk = ~clk;

  jt_sfg_bus #(.BASE(16'h3FF0), .AW(3), .WAIT_MIN(2)) dut (
    .clk(clk), .rst(rst), .addr(addr), .din(din),
    .wr_n(wr_n), .rd_n(rd_n), .slt_n(slt_n), .iorq_n(iorq_n), .m1_n(m1_n),
    .dout(dout), .dout_en(dout_en), .wait_n(wait_n), .int_n(int_n),
    .dev_addr(dev_addr), .dev_wdata(dev_wdata), .dev_wr(dev_wr), .dev_rd(dev_rd),
    .dev_rdata(dev_rdata), .dev_busy(dev_busy),
    .opm_irq_n(opm_irq_n), .midi_irq(midi_irq), .ext_irq(ext_irq)
  );

  // Passive observer of device strobes and WAIT
  always @(negedge clk) begin
    if (dev_wr) begin
      wr_cnt++;
      wr_a = dev_addr;
      wr_d = dev_wdata;
    end
    if (dev_rd) rd_cnt++;
    if (!wait_n) wlow++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic bus_cycle(input bit rd, input logic [15:0] a, input logic [7:0] d,
                           output bit saw_wait, output logic [7:0] rdv, output logic rden);
    int k;
    @(negedge clk);
    addr = a;
    din  = d;
    @(negedge clk);
    if (rd) rd_n = 1'b0;
    else    wr_n = 1'b0;
    saw_wait = 1'b0;
    for (int i = 0; i < 8 && !saw_wait; i++) begin
      @(negedge clk);
      if (!wait_n) saw_wait = 1'b1;
    end
    if (saw_wait) begin
      k = 0;
      while (!wait_n && k < 200) begin
        @(negedge clk);
        k++;
      end
      if (k >= 200) chk("wait_release_timeout", 32'(wait_n), 32'(1));
    end
    repeat (2) @(negedge clk);
    rdv  = dout;
    rden = dout_en;
    rd_n = 1'b1;
    wr_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  bit         sw;
  logic [7:0] rv;
  logic       re;
  int         w0, r0, l0, busy_wr, k;
  logic       busy_wait;

  initial begin
    rst = 1'b1; addr = 16'h0000; din = 8'h00;
    wr_n = 1'b1; rd_n = 1'b1; slt_n = 1'b1; iorq_n = 1'b1; m1_n = 1'b1;
    dev_rdata = 8'h80; dev_busy = 1'b0;
    opm_irq_n = 1'b1; midi_irq = 1'b0; ext_irq = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wait_n", 32'(wait_n), 32'(1));
    chk("rst_int_n", 32'(int_n), 32'(1));
    chk("rst_dout_en", 32'(dout_en), 32'(0));
    chk("rst_dout", 32'(dout), 32'h00);
    chk("rst_dev_wr", 32'(dev_wr), 32'(0));
    chk("rst_dev_rd", 32'(dev_rd), 32'(0));
    rst = 1'b0;
    slt_n = 1'b0;
    repeat (3) @(negedge clk);

    // Two plain writes
    w0 = wr_cnt; l0 = wlow;
    bus_cycle(1'b0, 16'h3FF0, 8'h20, sw, rv, re);
    chk("w1_count", 32'(wr_cnt - w0), 32'(1));
    chk("w1_addr", 32'(wr_a), 32'(0));
    chk("w1_data", 32'(wr_d), 32'h20);
    chk("w1_wait_ge3", 32'((wlow - l0) >= 3), 32'(1));
    w0 = wr_cnt; l0 = wlow;
    bus_cycle(1'b0, 16'h3FF1, 8'h55, sw, rv, re);
    chk("w2_count", 32'(wr_cnt - w0), 32'(1));
    chk("w2_addr", 32'(wr_a), 32'(1));
    chk("w2_data", 32'(wr_d), 32'h55);
    chk("w2_wait_ge3", 32'((wlow - l0) >= 3), 32'(1));

    // Device busy for 10 cycles
    w0 = wr_cnt;
    dev_busy = 1'b1;
    fork
      bus_cycle(1'b0, 16'h3FF1, 8'h77, sw, rv, re);
      begin
        repeat (10) @(negedge clk);
        busy_wr   = wr_cnt - w0;
        busy_wait = wait_n;
        dev_busy  = 1'b0;
      end
    join
    chk("busy_no_early_wr", 32'(busy_wr), 32'(0));
    chk("busy_wait_low", 32'(busy_wait), 32'(0));
    chk("busy_wr_once", 32'(wr_cnt - w0), 32'(1));
    chk("busy_wr_data", 32'(wr_d), 32'h77);

    // Device read
    r0 = rd_cnt;
    bus_cycle(1'b1, 16'h3FF0, 8'h00, sw, rv, re);
    chk("rd_dout", 32'(rv), 32'h80);
    chk("rd_dout_en", 32'(re), 32'(1));
    chk("rd_count", 32'(rd_cnt - r0), 32'(1));
    chk("rd_dout_en_off", 32'(dout_en), 32'(0));

    // Internal vector register and readback of it
    w0 = wr_cnt; r0 = rd_cnt;
    bus_cycle(1'b0, 16'h3FF3, 8'h40, sw, rv, re);
    chk("vec_no_dev_wr", 32'(wr_cnt - w0), 32'(0));
    bus_cycle(1'b1, 16'h3FF3, 8'h00, sw, rv, re);
    chk("vec_rd_ff", 32'(rv), 32'hFF);
    chk("vec_no_dev_rd", 32'(rd_cnt - r0), 32'(0));

    // Interrupt acknowledge
    slt_n = 1'b1;
    midi_irq = 1'b1; ext_irq = 1'b1;
    repeat (2) @(negedge clk);
    chk("irq_int_n", 32'(int_n), 32'(0));
    l0 = wlow;
    m1_n = 1'b0; iorq_n = 1'b0;
    repeat (4) @(negedge clk);
    chk("ack_dout_en", 32'(dout_en), 32'(1));
    chk("ack_midi_vec", 32'(dout), 32'h40);
    midi_irq = 1'b0;
    repeat (2) @(negedge clk);
    chk("ack_ext_vec", 32'(dout), 32'hFF);
    chk("ack_int_n_ext", 32'(int_n), 32'(0));
    m1_n = 1'b1; iorq_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("ack_end_dout_en", 32'(dout_en), 32'(0));
    chk("ack_no_wait", 32'(wlow - l0), 32'(0));
    ext_irq = 1'b0;
    opm_irq_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("opm_int_n", 32'(int_n), 32'(0));
    opm_irq_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("irq_clear_int_n", 32'(int_n), 32'(1));

    // Misses: outside window, then slot deselected
    slt_n = 1'b0;
    w0 = wr_cnt; r0 = rd_cnt;
    bus_cycle(1'b0, 16'h3FE8, 8'h11, sw, rv, re);
    chk("miss_addr_wait", 32'(sw), 32'(0));
    chk("miss_addr_wr", 32'(wr_cnt - w0), 32'(0));
    slt_n = 1'b1;
    bus_cycle(1'b1, 16'h3FF0, 8'h00, sw, rv, re);
    chk("miss_slt_wait", 32'(sw), 32'(0));
    chk("miss_slt_rd", 32'(rd_cnt - r0), 32'(0));
    chk("miss_slt_dout_en", 32'(re), 32'(0));

    // Slot deselected during WAIT aborts the access
    slt_n = 1'b0; dev_busy = 1'b1;
    w0 = wr_cnt;
    @(negedge clk); addr = 16'h3FF2; din = 8'h99;
    @(negedge clk); wr_n = 1'b0;
    k = 0;
    while (wait_n && k < 10) begin @(negedge clk); k++; end
    chk("abort_wait_seen", 32'(wait_n), 32'(0));
    slt_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_wait_rel", 32'(wait_n), 32'(1));
    dev_busy = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_no_wr", 32'(wr_cnt - w0), 32'(0));
    wr_n = 1'b1;
    repeat (5) @(negedge clk);

    // Reset while in WAIT
    slt_n = 1'b0; dev_busy = 1'b1;
    w0 = wr_cnt;
    @(negedge clk); addr = 16'h3FF1; din = 8'h33;
    @(negedge clk); wr_n = 1'b0;
    k = 0;
    while (wait_n && k < 10) begin @(negedge clk); k++; end
    chk("rstw_wait_seen", 32'(wait_n), 32'(0));
    rst = 1'b1;
    #1;
    chk("rstw_wait_n", 32'(wait_n), 32'(1));
    wr_n = 1'b1; dev_busy = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstw_no_wr", 32'(wr_cnt - w0), 32'(0));
    bus_cycle(1'b0, 16'h3FF2, 8'hA5, sw, rv, re);
    chk("rstw_next_count", 32'(wr_cnt - w0), 32'(1));
    chk("rstw_next_addr", 32'(wr_a), 32'(2));
    chk("rstw_next_data", 32'(wr_d), 32'hA5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
